// File: rtl/mdsa_sort_controller_if.sv
// Valid/ready stream bundle between the sort controller and its producer/consumer.
// The slave modport is the controller view; the master modport is the environment view.
interface mdsa_sort_controller_if #(
    parameter int DW = 32
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/mdsa_sort_controller.sv
// Feeder/drain controller for the NxN multidimensional bitonic sorter array.
// Loads N*N words from a serial stream, sequences the sorter through its
// row/column phases, captures the transposed result and streams it back out.
// Optional build macro MDSA_CTRL_PERF_CNT_EN adds the perf_cycles output,
// which reports the KICK..CAPTURE cycle count of the most recent sort.
module mdsa_sort_controller #(
    parameter int             N          = 8,
    parameter int             DW         = 32,
    parameter int             SORT_LAT   = 6,
    parameter int             NUM_PHASES = 7,
    parameter logic [N-1:0]   ROW_DIR    = 8'hAA,
    parameter logic [N-1:0]   COL_DIR    = 8'h00
) (
    input  logic                 clk,
    input  logic                 rst,
    mdsa_sort_controller_if.slave bus,
    output logic                 busy,
    output logic                 done,
    output logic                 sort_rst,
    output logic                 sort_en,
    output logic                 sort_start,
    output logic                 sort_trans,
    output logic [N-1:0]         sort_dir,
    output logic [N*N*DW-1:0]    sort_data_new,
    input  logic [N*N*DW-1:0]    sort_data_final
`ifdef MDSA_CTRL_PERF_CNT_EN
    ,
    output logic [31:0]          perf_cycles
`endif
);

    localparam int WORDS  = N * N;
    localparam int WIDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int CNT_W  = (SORT_LAT > 1) ? $clog2(SORT_LAT) : 1;
    localparam int PH_W   = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1;

    typedef enum logic [2:0] {
        LOAD,
        KICK,
        WAIT,
        STEP,
        CAPTURE,
        UNLOAD
    } state_t;

    state_t              state_q, state_d;
    logic [WIDX_W-1:0]   widx_q, widx_d;
    logic [WIDX_W-1:0]   ridx_q, ridx_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [PH_W-1:0]     phase_q, phase_d;
    logic [WORDS*DW-1:0] data_new_q, data_new_d;
    logic [WORDS*DW-1:0] result_q, result_d;
    logic [DW-1:0]       out_data_q, out_data_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                sort_rst_q;
    logic                sort_en_q, sort_en_d;
    logic                sort_start_q, sort_start_d;
    logic                sort_trans_q, sort_trans_d;
    logic [N-1:0]        sort_dir_q, sort_dir_d;
    logic                in_hs;
    logic                out_hs;

    // Handshake readiness is decoded from state; loading also waits out the sorter reset and the done cycle.
    assign bus.in_ready  = (state_q == LOAD) && !sort_rst_q && !done_q;
    assign bus.out_valid = (state_q == UNLOAD);
    assign bus.out_data  = out_data_q;
    assign in_hs         = bus.in_ready && bus.in_valid;
    assign out_hs        = bus.out_valid && bus.out_ready;

    assign busy          = busy_q;
    assign done          = done_q;
    assign sort_rst      = sort_rst_q;
    assign sort_en       = sort_en_q;
    assign sort_start    = sort_start_q;
    assign sort_trans    = sort_trans_q;
    assign sort_dir      = sort_dir_q;
    assign sort_data_new = data_new_q;

    // Next-state, counter, data-path and registered-output decode for the sort sequence.
    always_comb begin
        state_d    = state_q;
        widx_d     = widx_q;
        ridx_d     = ridx_q;
        cnt_d      = cnt_q;
        phase_d    = phase_q;
        data_new_d = data_new_q;
        result_d   = result_q;
        out_data_d = out_data_q;
        done_d     = 1'b0;

        case (state_q)
            LOAD: begin
                if (in_hs) begin
                    data_new_d[int'(widx_q) * DW +: DW] = bus.in_data;
                    if (widx_q == WIDX_W'(WORDS - 1)) begin
                        widx_d  = '0;
                        phase_d = '0;
                        state_d = KICK;
                    end else begin
                        widx_d = widx_q + WIDX_W'(1);
                    end
                end
            end
            KICK: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q == CNT_W'(SORT_LAT - 1)) begin
                    cnt_d = '0;
                    if (phase_q == PH_W'(NUM_PHASES - 1)) begin
                        state_d = CAPTURE;
                    end else begin
                        phase_d = phase_q + PH_W'(1);
                        state_d = STEP;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            STEP: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            CAPTURE: begin
                result_d   = sort_data_final;
                out_data_d = sort_data_final[DW-1:0];
                ridx_d     = '0;
                state_d    = UNLOAD;
            end
            UNLOAD: begin
                if (out_hs) begin
                    if (ridx_q == WIDX_W'(WORDS - 1)) begin
                        ridx_d     = '0;
                        out_data_d = '0;
                        done_d     = 1'b1;
                        state_d    = LOAD;
                    end else begin
                        ridx_d     = ridx_q + WIDX_W'(1);
                        out_data_d = result_q[(int'(ridx_q) + 1) * DW +: DW];
                    end
                end
            end
            default: begin
                state_d = LOAD;
            end
        endcase

        busy_d       = (state_d != LOAD);
        sort_en_d    = (state_d == KICK) || (state_d == WAIT) || (state_d == STEP);
        sort_start_d = (state_d == KICK);
        sort_trans_d = (state_d == KICK) || (state_d == STEP);
        sort_dir_d   = phase_d[0] ? COL_DIR : ROW_DIR;
    end

    // State, counters, buffers and registered outputs; reset aborts any run in progress.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= LOAD;
            widx_q       <= '0;
            ridx_q       <= '0;
            cnt_q        <= '0;
            phase_q      <= '0;
            data_new_q   <= '0;
            result_q     <= '0;
            out_data_q   <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            sort_rst_q   <= 1'b1;
            sort_en_q    <= 1'b0;
            sort_start_q <= 1'b0;
            sort_trans_q <= 1'b0;
            sort_dir_q   <= ROW_DIR;
        end else begin
            state_q      <= state_d;
            widx_q       <= widx_d;
            ridx_q       <= ridx_d;
            cnt_q        <= cnt_d;
            phase_q      <= phase_d;
            data_new_q   <= data_new_d;
            result_q     <= result_d;
            out_data_q   <= out_data_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            sort_rst_q   <= 1'b0;
            sort_en_q    <= sort_en_d;
            sort_start_q <= sort_start_d;
            sort_trans_q <= sort_trans_d;
            sort_dir_q   <= sort_dir_d;
        end
    end

`ifdef MDSA_CTRL_PERF_CNT_EN
    logic [31:0] perf_run_q, perf_run_d;
    logic [31:0] perf_cycles_q, perf_cycles_d;

    assign perf_cycles = perf_cycles_q;

    // Running count starts at KICK; CAPTURE adds its own cycle and publishes the total.
    always_comb begin
        perf_run_d    = perf_run_q;
        perf_cycles_d = perf_cycles_q;
        case (state_q)
            KICK:       perf_run_d    = 32'd1;
            WAIT, STEP: perf_run_d    = perf_run_q + 32'd1;
            CAPTURE:    perf_cycles_d = perf_run_q + 32'd1;
            default:    perf_run_d    = perf_run_q;
        endcase
    end

    // Performance counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_run_q    <= '0;
            perf_cycles_q <= '0;
        end else begin
            perf_run_q    <= perf_run_d;
            perf_cycles_q <= perf_cycles_d;
        end
    end
`endif

endmodule

// File: tb/tb_mdsa_sort_controller.sv
// Self-checking bench for mdsa_sort_controller: a cycle-schedule model of the
// sort sequence plus a sorted/transposed matrix model acting as the sorter.
module tb_mdsa_sort_controller;

    localparam int N          = 8;
    localparam int DW         = 32;
    localparam int SORT_LAT   = 6;
    localparam int NUM_PHASES = 7;
    localparam int WORDS      = N * N;
    localparam int CAP_IDX    = NUM_PHASES * SORT_LAT + (NUM_PHASES - 1) + 1;
    localparam logic [N-1:0] ROW_DIR = 8'hAA;
    localparam logic [N-1:0] COL_DIR = 8'h00;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic busy, done, sort_rst, sort_en, sort_start, sort_trans;
    logic [N-1:0]        sort_dir;
    logic [WORDS*DW-1:0] sort_data_new;
    logic [WORDS*DW-1:0] sort_data_final = '0;
`ifdef MDSA_CTRL_PERF_CNT_EN
    logic [31:0] perf_cycles;
`endif

    mdsa_sort_controller_if #(.DW(DW)) bus ();

    mdsa_sort_controller #(
        .N(N), .DW(DW), .SORT_LAT(SORT_LAT), .NUM_PHASES(NUM_PHASES),
        .ROW_DIR(ROW_DIR), .COL_DIR(COL_DIR)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .busy(busy),
        .done(done),
        .sort_rst(sort_rst),
        .sort_en(sort_en),
        .sort_start(sort_start),
        .sort_trans(sort_trans),
        .sort_dir(sort_dir),
        .sort_data_new(sort_data_new),
        .sort_data_final(sort_data_final)
`ifdef MDSA_CTRL_PERF_CNT_EN
        ,
        .perf_cycles(perf_cycles)
`endif
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    logic [DW-1:0]       load_q[$];
    logic [DW-1:0]       exp_word[WORDS];
    logic [WORDS*DW-1:0] final_vec = '0;
    int kick_cyc  = -1;
    int out_idx   = 0;
    int rel_cyc   = 0;
    bit kick_next = 1'b0;
    bit running   = 1'b0;
    bit unloading = 1'b0;
    bit done_next = 1'b0;
    bit done_exp  = 1'b0;

    task automatic checkOutput(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Sorter model: the handshaked words sorted ascending, laid out row-major, then transposed.
    function automatic void buildModel();
        logic [DW-1:0] a[WORDS];
        logic [DW-1:0] t;
        for (int k = 0; k < WORDS; k++) a[k] = load_q[k];
        for (int i = 1; i < WORDS; i++) begin
            for (int j = i; j > 0 && a[j-1] > a[j]; j--) begin
                t = a[j]; a[j] = a[j-1]; a[j-1] = t;
            end
        end
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                exp_word[r*N + c] = a[c*N + r];
        for (int k = 0; k < WORDS; k++) final_vec[k*DW +: DW] = exp_word[k];
    endfunction

    // Per-cycle monitor: checks the whole control schedule and plays the sorter.
    always @(negedge clk) begin
        if (!rst) begin
            load_q.delete();
            kick_cyc = -1; out_idx = 0; rel_cyc = 0;
            kick_next = 0; running = 0; unloading = 0; done_next = 0; done_exp = 0;
            sort_data_final = '0;
        end else begin
            if (rel_cyc < 2) rel_cyc++;
            checkOutput("sort_rst", sort_rst, rel_cyc == 1);
            done_exp  = done_next;
            done_next = 0;
            checkOutput("done", done, done_exp);
            checkOutput("in_ready", bus.in_ready, !running && rel_cyc > 1 && !done_exp);

            if (kick_next) begin
                kick_next = 0;
                kick_cyc  = 0;
                buildModel();
                for (int k = 0; k < WORDS; k++)
                    checkOutput("sort_data_new", sort_data_new[k*DW +: DW], load_q[k]);
                load_q.delete();
            end else if (kick_cyc >= 0) begin
                kick_cyc++;
            end
            if (kick_cyc == CAP_IDX + 1) begin
                kick_cyc  = -1;
                unloading = 1;
`ifdef MDSA_CTRL_PERF_CNT_EN
                checkOutput("perf_cycles", perf_cycles, CAP_IDX + 1);
`endif
            end

            if (kick_cyc >= 0) begin
                checkOutput("sort_en", sort_en, kick_cyc < CAP_IDX);
                checkOutput("sort_start", sort_start, kick_cyc == 0);
                checkOutput("sort_trans", sort_trans,
                            (kick_cyc < CAP_IDX) && (kick_cyc % (SORT_LAT + 1) == 0));
                if (kick_cyc < CAP_IDX)
                    checkOutput("sort_dir", sort_dir,
                                (((kick_cyc / (SORT_LAT + 1)) % 2) == 1) ? COL_DIR : ROW_DIR);
            end else begin
                checkOutput("idle_sort_en", sort_en, 0);
                checkOutput("idle_sort_start", sort_start, 0);
                checkOutput("idle_sort_trans", sort_trans, 0);
            end
            checkOutput("busy", busy, (kick_cyc >= 0) || unloading);
            checkOutput("out_valid", bus.out_valid, unloading);

            sort_data_final = (kick_cyc == CAP_IDX) ? final_vec : ~final_vec;

            if (bus.in_valid && bus.in_ready) begin
                load_q.push_back(bus.in_data);
                if (load_q.size() == WORDS) begin
                    running   = 1;
                    kick_next = 1;
                end
            end

            if (unloading && bus.out_valid) begin
                checkOutput("out_data", bus.out_data, exp_word[out_idx]);
                if (bus.out_ready) begin
                    out_idx++;
                    if (out_idx == WORDS) begin
                        out_idx   = 0;
                        unloading = 0;
                        running   = 0;
                        done_next = 1;
                    end
                end
            end
        end
    end

    // Streams one matrix in, holding each word until it is accepted; in_valid gated at validPct percent.
    task automatic applyStimulus(input logic [DW-1:0] words[WORDS], input int validPct);
        int k = 0;
        int cyc = 0;
        bit hs;
        @(posedge clk); #1;
        while (k < WORDS && cyc < 5000) begin
            bus.in_valid = (int'($urandom_range(99)) < validPct);
            bus.in_data  = words[k];
            @(negedge clk);
            hs = bus.in_valid && bus.in_ready;
            @(posedge clk); #1;
            if (hs) k++;
            cyc++;
        end
        bus.in_valid = 1'b0;
        checkOutput("load_count", k, WORDS);
    endtask

    // Drives out_ready (0: always, 1: 1-0-0-1 pattern, 2: random) until done; optionally spams in_valid.
    task automatic drainResult(input int stallMode, input bit junkIn);
        bit seen = 0;
        for (int cyc = 0; cyc < 3000 && !seen; cyc++) begin
            @(posedge clk); #1;
            case (stallMode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
                default: bus.out_ready = 1'($urandom_range(1));
            endcase
            if (junkIn) begin
                bus.in_valid = 1'b1;
                bus.in_data  = $urandom;
            end
            @(negedge clk);
            seen = done;
        end
        checkOutput("drain_done_seen", seen, 1);
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [DW-1:0] words[WORDS];
        bit found;

        bus.in_valid  = 1'b1;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_in_ready", bus.in_ready, 0);
        checkOutput("rst_sort_rst", sort_rst, 1);
        checkOutput("rst_out_valid", bus.out_valid, 0);
        checkOutput("rst_out_data", bus.out_data, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_sort_en", sort_en, 0);
        checkOutput("rst_sort_start", sort_start, 0);
        checkOutput("rst_sort_trans", sort_trans, 0);
        checkOutput("rst_sort_dir", sort_dir, ROW_DIR);
        checkOutput("rst_data_new_lo", sort_data_new[DW-1:0], 0);
        checkOutput("rst_data_new_hi", sort_data_new[WORDS*DW-1 -: DW], 0);
`ifdef MDSA_CTRL_PERF_CNT_EN
        checkOutput("rst_perf_cycles", perf_cycles, 0);
`endif
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);

        // Descending 63..0, back to back, no back-pressure.
        for (int k = 0; k < WORDS; k++) words[k] = DW'(WORDS - 1 - k);
        applyStimulus(words, 100);
        drainResult(0, 1'b0);

        // Random data, gated in_valid, 1-0-0-1 out_ready, in_valid spam outside LOAD.
        for (int k = 0; k < WORDS; k++) words[k] = $urandom;
        applyStimulus(words, 50);
        drainResult(1, 1'b1);

        // Abort during phase 3, then a fresh run.
        for (int k = 0; k < WORDS; k++) words[k] = $urandom;
        applyStimulus(words, 70);
        found = 0;
        for (int cyc = 0; cyc < 200 && !found; cyc++) begin
            @(posedge clk); #2;
            if (kick_cyc == 3 * (SORT_LAT + 1) + 3) found = 1;
        end
        checkOutput("abort_point_reached", found, 1);
        rst = 1'b0;
        #1;
        checkOutput("abort_out_valid", bus.out_valid, 0);
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_sort_en", sort_en, 0);
        checkOutput("abort_sort_rst", sort_rst, 1);
        checkOutput("abort_in_ready", bus.in_ready, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        for (int k = 0; k < WORDS; k++) words[k] = $urandom_range(15);
        applyStimulus(words, 100);
        drainResult(2, 1'b1);

        repeat (5) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mdsa_sort_controller.md
Name: mdsa_sort_controller

Overview:
- Upstream feeder and downstream drain for the 8x8 multidimensional bitonic sorter array.
- Collects a 64-word matrix from a serial valid/ready stream and presents it as the sorter's parallel load word.
- Sequences en/start/trans/dir through NUM_PHASES row/column sort phases, captures the final transposed result, then streams it back out word by word.

Parameters:
- N, 8, matrix side; sorter holds N*N words.
- DW, 32, word width.
- SORT_LAT, 6, clk cycles the sorter needs per phase before its output is valid.
- NUM_PHASES, 7, number of sort phases per matrix (must be ≥1).
- ROW_DIR, 8'hAA, sort_dir used on even phases (snake pattern).
- COL_DIR, 8'h00, sort_dir used on odd phases.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  controller accepts a word.
- in_data  in  DW  input word, row-major order.
- out_valid  out  1  result word valid.
- out_ready  in  1  consumer accepts a result word.
- out_data  out  DW  result word, row-major order.
- busy  out  1  high in every state except LOAD.
- done  out  1  one-cycle pulse after the last result word is accepted.
- sort_rst  out  1  active-high synchronous reset for the sorter.
- sort_en  out  1  sorter enable.
- sort_start  out  1  sorter selects the new-data path.
- sort_trans  out  1  sorter register-bank strobe.
- sort_dir  out  N  per-row sort direction.
- sort_data_new  out  N*N*DW  assembled matrix.
- sort_data_final  in  N*N*DW  transposed sorter result.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=LOAD; all counters 0.
  - sort_data_new=0, result buffer=0.
  - in_ready=0, out_valid=0, out_data=0, done=0, busy=0.
  - sort_en=0, sort_start=0, sort_trans=0, sort_dir=ROW_DIR.
  - sort_rst=1; it stays 1 through the first clk edge after release, then 0 (registered).
- Reset asserted mid-run aborts immediately; no partial result is ever emitted.
- All outputs are registered except in_ready and out_valid, which are decoded from state.
- LOAD:
  - in_ready=1.
  - Each handshake writes in_data to sort_data_new[widx*DW +: DW] and increments widx (0..N*N-1).
  - The handshake at widx=N*N-1 moves to KICK and resets widx to 0.
- KICK (1 cycle): sort_en=1, sort_start=1, sort_trans=1, phase=0, sort_dir=ROW_DIR. Next state is WAIT with cnt=0.
- WAIT:
  - sort_en=1, sort_start=0, sort_trans=0; cnt increments each cycle.
  - At cnt=SORT_LAT-1: go to CAPTURE if phase=NUM_PHASES-1, otherwise go to STEP.
- STEP (1 cycle):
  - sort_trans=1, sort_en=1, sort_start=0.
  - phase increments on entry, so sort_dir already reflects the new phase during STEP.
  - Next state is WAIT with cnt=0.
- sort_dir = ROW_DIR when phase is even, COL_DIR when phase is odd. It is held constant for the whole WAIT.
- CAPTURE (1 cycle): result buffer <= sort_data_final, sort_en=0. Next state is UNLOAD with ridx=0.
- UNLOAD:
  - out_valid=1, out_data=result[ridx*DW +: DW].
  - ridx advances only on out_valid&out_ready.
  - out_data is held stable while out_ready=0.
  - The handshake at ridx=N*N-1 returns to LOAD and pulses done for one cycle.
- Cycle count from KICK through CAPTURE inclusive is 1 + NUM_PHASES*SORT_LAT + (NUM_PHASES-1) + 1; with defaults this is 50.
- Boundaries:
  - in_valid is ignored outside LOAD (in_ready=0), including the cycle of the final out handshake. A new matrix is accepted no earlier than the cycle after done.
  - NUM_PHASES=1: go straight KICK→WAIT→CAPTURE with no STEP.
  - Counters are sized $clog2 of their limit; no wrap occurs beyond the stated limits.
  - Back-pressure: an arbitrarily long out_ready=0 stalls UNLOAD with no data loss.

Optional Feature:
- Macro MDSA_CTRL_PERF_CNT_EN.
- Defined:
  - Adds output perf_cycles [31:0], reset 0.
  - Counts cycles from KICK through CAPTURE inclusive and latches the total at CAPTURE.
  - Holds that value until the next CAPTURE or reset.
- Undefined: the port and its counter do not exist; all other behaviour is identical.

Test Plan:
- Reset with in_valid=1 held: in_ready=0, sort_rst=1 for one clk after release, all outputs 0; in_ready rises in the next cycle.
- Stream words 63..0 back-to-back: sort_data_new word k = 63-k; KICK pulse seen with sort_start=1. After 50 cycles (KICK..CAPTURE), out words 0..63 equal the sorter model's final transposed matrix; done pulses once.
- Gate in_valid randomly during LOAD: only handshaked words are stored; the word order matches the handshake order.
- Toggle out_ready 1-0-0-1 during UNLOAD: out_data stays constant while stalled; 64 words are emitted exactly once each.
- Observe sort_dir per phase: AA,00,AA,00,AA,00,AA; one sort_trans pulse per STEP (6 total) plus KICK.
- Assert rst during WAIT of phase 3, then release and load a new matrix: no out_valid before the new result; with MDSA_CTRL_PERF_CNT_EN defined, perf_cycles=50 after the new run.
